xge_pkt_tx_gen: RTL and testbench

//  Synthesizable packet source for the 10GE MAC transmit client interface (pkt_tx_*).

---
 rtl/xge_pkt_tx_gen_pkg.sv | 31 +++
 rtl/xge_pkt_tx_gen_if.sv | 21 ++
 rtl/xge_pkt_tx_gen_lfsr.sv | 27 ++
 rtl/xge_pkt_tx_gen.sv | 208 ++++++++++++++++++++
 tb/tb_xge_pkt_tx_gen.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xge_pkt_tx_gen_pkg.sv
// rtl/xge_pkt_tx_gen_pkg.sv - shared types, header marker, LFSR step and length clamp for the packet source
package xge_txgen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOP,
        BODY,
        IPG,
        DONE
    } state_t;

    localparam logic [15:0] HDR_MARKER = 16'hA5C3;

    // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

    function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        if (len < lo)
            return lo;
        else if (len > hi)
            return hi;
        return len;
    endfunction

endpackage

// File: rtl/xge_pkt_tx_gen_if.sv
// rtl/xge_pkt_tx_gen_if.sv - pkt_tx_* client interface between the packet source and the 10GE MAC
interface xge_pkt_tx_gen_if;

    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_full;

    modport master (
        output pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
        input  pkt_tx_full
    );

    modport slave (
        input  pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
        output pkt_tx_full
    );

endinterface

// File: rtl/xge_pkt_tx_gen_lfsr.sv
// rtl/xge_pkt_tx_gen_lfsr.sv - 16-bit Fibonacci LFSR used for random frame lengths
module xge_lfsr16
    import xge_txgen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step,
    input  logic        i_load,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= SEED;
        else if (i_load)
            r_q <= SEED;
        else if (i_step)
            r_q <= lfsr_next(r_q);
    end

    assign o_q = r_q;

endmodule

// File: rtl/xge_pkt_tx_gen.sv
// rtl/xge_pkt_tx_gen.sv - header + byte-ramp frame source for the 10GE MAC; XGE_TXGEN_BYTE_CNT_EN adds o_bytes_sent
module xge_pkt_tx_gen
    import xge_txgen_pkg::*;
#(
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned IPG_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_156m25,
    input  logic                  reset_156m25,
    xge_pkt_tx_gen_if.master      tx,
    input  logic                  i_enable,
    input  logic [15:0]           i_pkt_count,
    input  logic                  i_rand_len,
    input  logic [10:0]           i_fixed_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_pkts_sent
`ifdef XGE_TXGEN_BYTE_CNT_EN
    ,
    output logic [31:0]           o_bytes_sent
`endif
);

    localparam logic [10:0] C_MIN      = 11'(MIN_LEN);
    localparam logic [10:0] C_MAX      = 11'(MAX_LEN);
    localparam logic [15:0] C_IPG_LAST = (IPG_CYCLES == 0) ? 16'd0 : 16'(IPG_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic        w_present, w_eop, w_sop_entry, w_run_start, w_gap_end;
    logic [15:0] w_lfsr_q;
    logic [10:0] w_len_new, w_len_m1, w_base;
    logic [15:0] w_sent_cmp;
    logic [63:0] w_hdr_word, w_body_word;

    logic [10:0] r_len;
    logic [7:0]  r_word_idx, r_last_idx;
    logic [31:0] r_seq;
    logic [15:0] r_pkts_sent, r_ipg_cnt;
    logic        r_done, r_busy;
    logic        r_val, r_sop, r_eop;
    logic [2:0]  r_mod;
    logic [63:0] r_data;
`ifdef XGE_TXGEN_BYTE_CNT_EN
    logic [31:0] r_bytes_sent;
`endif

    xge_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk_156m25),
        .rst    (reset_156m25),
        .i_step (w_sop_entry),
        .i_load (1'b0),
        .o_q    (w_lfsr_q)
    );

    assign w_len_new = i_rand_len ? clamp_len(w_lfsr_q[10:0], C_MIN, C_MAX)
                                  : clamp_len(i_fixed_len, C_MIN, C_MAX);
    assign w_len_m1  = w_len_new - 11'd1;

    // With no gap the end-of-run decision is made on the eop edge, before the count has stepped
    assign w_sent_cmp = (IPG_CYCLES == 0) ? r_pkts_sent + 16'd1 : r_pkts_sent;

    always_comb begin
        w_state_next = r_state;
        w_present    = 1'b0;
        w_eop        = 1'b0;
        w_sop_entry  = 1'b0;
        w_run_start  = 1'b0;
        w_gap_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable && !r_done) begin
                    w_state_next = SOP;
                    w_sop_entry  = 1'b1;
                    w_run_start  = 1'b1;
                end
            end
            SOP: begin
                if (!tx.pkt_tx_full) begin
                    w_present    = 1'b1;
                    w_state_next = BODY;
                end
            end
            BODY: begin
                if (!tx.pkt_tx_full) begin
                    w_present = 1'b1;
                    if (r_word_idx == r_last_idx) begin
                        w_eop = 1'b1;
                        if (IPG_CYCLES == 0)
                            w_gap_end = 1'b1;
                        else
                            w_state_next = IPG;
                    end
                end
            end
            IPG: begin
                if (r_ipg_cnt == C_IPG_LAST)
                    w_gap_end = 1'b1;
            end
            DONE: begin
                if (!i_enable)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_gap_end) begin
            if (w_sent_cmp == i_pkt_count && i_pkt_count != 16'd0) begin
                w_state_next = DONE;
            end else if (!i_enable) begin
                w_state_next = IDLE;
            end else begin
                w_state_next = SOP;
                w_sop_entry  = 1'b1;
            end
        end
    end

    assign w_hdr_word = {r_seq, HDR_MARKER, 5'd0, r_len};
    assign w_base     = {r_word_idx, 3'b000};

    always_comb begin
        w_body_word = '0;
        for (int j = 0; j < 8; j++) begin
            if (w_base + 11'(j) < r_len)
                w_body_word[8*j +: 8] = r_seq[7:0] + w_base[7:0] + 8'(j);
        end
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_last_idx  <= '0;
            r_seq       <= '0;
            r_pkts_sent <= '0;
            r_ipg_cnt   <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_val       <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_mod       <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == SOP) || (w_state_next == BODY) || (w_state_next == IPG);
            r_done  <= (w_state_next == DONE);
            r_ipg_cnt <= (r_state == IPG) ? r_ipg_cnt + 16'd1 : 16'd0;

            if (w_sop_entry) begin
                r_len      <= w_len_new;
                r_last_idx <= w_len_m1[10:3];
            end

            if (w_run_start)
                r_pkts_sent <= '0;
            else if (w_eop)
                r_pkts_sent <= r_pkts_sent + 16'd1;

            if (w_eop)
                r_seq <= r_seq + 32'd1;

            if (w_present)
                r_word_idx <= (r_state == SOP) ? 8'd1 : r_word_idx + 8'd1;

            // While the MAC is full the last word stays on the bus with val low
            if (tx.pkt_tx_full) begin
                r_val <= 1'b0;
            end else if (w_present) begin
                r_val  <= 1'b1;
                r_sop  <= (r_state == SOP);
                r_eop  <= w_eop;
                r_mod  <= w_eop ? r_len[2:0] : 3'd0;
                r_data <= (r_state == SOP) ? w_hdr_word : w_body_word;
            end else begin
                r_val <= 1'b0;
                r_sop <= 1'b0;
                r_eop <= 1'b0;
                r_mod <= 3'd0;
            end
        end
    end

`ifdef XGE_TXGEN_BYTE_CNT_EN
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25)
            r_bytes_sent <= '0;
        else if (w_run_start)
            r_bytes_sent <= '0;
        else if (w_eop)
            r_bytes_sent <= r_bytes_sent + 32'(r_len);
    end

    assign o_bytes_sent = r_bytes_sent;
`endif

    assign tx.pkt_tx_val  = r_val;
    assign tx.pkt_tx_sop  = r_sop;
    assign tx.pkt_tx_eop  = r_eop;
    assign tx.pkt_tx_mod  = r_mod;
    assign tx.pkt_tx_data = r_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_pkts_sent    = r_pkts_sent;

endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// tb/tb_xge_pkt_tx_gen.sv - directed bench for xge_pkt_tx_gen (default parameters)
module tb_xge_pkt_tx_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pkt_count = '0;
    logic        rand_len = 1'b0;
    logic [10:0] fixed_len = '0;
    logic        busy, done;
    logic [15:0] pkts_sent;
`ifdef XGE_TXGEN_BYTE_CNT_EN
    logic [31:0] bytes_sent;
`endif

    xge_pkt_tx_gen_if tx();

    xge_pkt_tx_gen dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .tx           (tx),
        .i_enable     (enable),
        .i_pkt_count  (pkt_count),
        .i_rand_len   (rand_len),
        .i_fixed_len  (fixed_len),
        .o_busy       (busy),
        .o_done       (done),
        .o_pkts_sent  (pkts_sent)
`ifdef XGE_TXGEN_BYTE_CNT_EN
        ,
        .o_bytes_sent (bytes_sent)
`endif
    );

    always #3 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] fw[$];
    logic [2:0]  f_mod;
    int          f_pre, f_stall, f_sopx, f_ok;
    logic [31:0] exp_seq;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_run(input int len, input int cnt, input logic rnd);
        fixed_len = 11'(len);
        pkt_count = 16'(cnt);
        rand_len  = rnd;
        enable    = 1'b1;
    endtask

    task automatic stop_run();
        enable   = 1'b0;
        rand_len = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [63:0] exp_word(input logic [31:0] seq, input int len, input int i);
        logic [63:0] w;
        w = '0;
        if (i == 0)
            return {seq, 16'hA5C3, 16'(len)};
        for (int j = 0; j < 8; j++)
            if (8 * i + j < len)
                w[8*j +: 8] = 8'(int'(seq[7:0]) + 8 * i + j);
        return w;
    endfunction

    function automatic int clampb(input int v);
        if (v < 64)
            return 64;
        if (v > 1518)
            return 1518;
        return v;
    endfunction

    // Gathers one frame from sop to eop; f_pre counts samples before sop, including the one at entry
    task automatic collect_frame();
        int n;
        fw.delete();
        f_pre = 0;
        f_stall = 0;
        f_sopx = 0;
        f_ok = 0;
        n = 0;
        while (!(tx.pkt_tx_val && tx.pkt_tx_sop) && n < 4000) begin
            tick();
            n++;
            f_pre++;
        end
        if (n >= 4000)
            return;
        n = 0;
        forever begin
            if (tx.pkt_tx_val) begin
                fw.push_back(tx.pkt_tx_data);
                if (fw.size() > 1 && tx.pkt_tx_sop)
                    f_sopx++;
                if (tx.pkt_tx_eop) begin
                    f_mod = tx.pkt_tx_mod;
                    f_ok = 1;
                    return;
                end
            end else begin
                f_stall++;
            end
            tick();
            n++;
            if (n > 400)
                return;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({tx.pkt_tx_val, tx.pkt_tx_sop, tx.pkt_tx_eop, tx.pkt_tx_mod} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {tx.pkt_tx_val, tx.pkt_tx_sop, tx.pkt_tx_eop, tx.pkt_tx_mod});
        end
        vectors++;
        if (tx.pkt_tx_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", tx.pkt_tx_data);
        end
        vectors++;
        if ({busy, done, pkts_sent} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b pkts=%0d want 0/0/0", busy, done, pkts_sent);
        end
        rst = 1'b0;
        tick();
        exp_seq = 0;
    endtask

    task automatic test_fixed_64();
        start_run(64, 1, 1'b0);
        collect_frame();
        vectors++;
        if (f_ok != 1 || fw.size() != 8) begin
            miscompares++;
            $display("FAIL len64_words: ok=%0d words=%0d want 1/8", f_ok, fw.size());
        end
        vectors++;
        if (fw.size() > 0 && fw[0] !== 64'h00000000_A5C3_0040) begin
            miscompares++;
            $display("FAIL len64_w0: got %h want 00000000a5c30040", fw[0]);
        end
        for (int i = 1; i < fw.size(); i++) begin
            vectors++;
            if (fw[i] !== exp_word(exp_seq, 64, i)) begin
                miscompares++;
                $display("FAIL len64_w%0d: got %h want %h", i, fw[i], exp_word(exp_seq, 64, i));
            end
        end
        vectors++;
        if (f_mod !== 3'd0 || f_sopx != 0 || f_stall != 0) begin
            miscompares++;
            $display("FAIL len64_flags: mod=%0d extra_sop=%0d gaps=%0d want 0/0/0", f_mod, f_sopx, f_stall);
        end
        repeat (4) tick();
        vectors++;
        if (done !== 1'b1 || pkts_sent !== 16'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len64_done: done=%b pkts=%0d busy=%b want 1/1/0", done, pkts_sent, busy);
        end
        stop_run();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_release: got %b want 0", done);
        end
        exp_seq++;
    endtask

    task automatic test_fixed_65();
        logic [63:0] e;
        e = {56'd0, 8'(exp_seq[7:0] + 8'd64)};
        start_run(65, 1, 1'b0);
        collect_frame();
        vectors++;
        if (f_ok != 1 || fw.size() != 9 || f_mod !== 3'd1) begin
            miscompares++;
            $display("FAIL len65_shape: ok=%0d words=%0d mod=%0d want 1/9/1", f_ok, fw.size(), f_mod);
        end
        vectors++;
        if (fw.size() == 9 && (fw[8] !== e || fw[0] !== {exp_seq, 16'hA5C3, 16'd65})) begin
            miscompares++;
            $display("FAIL len65_words: w0=%h w8=%h want w8 %h", fw[0], fw[8], e);
        end
        stop_run();
        exp_seq++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_seq = 0;
        start_run(64, 3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            collect_frame();
            vectors++;
            if (f_ok != 1 || fw.size() != 8 || fw[0][63:32] !== 32'(k)) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: ok=%0d words=%0d seq=%0d want 1/8/%0d", k, f_ok, fw.size(),
                         fw.size() > 0 ? fw[0][63:32] : 32'hFFFFFFFF, k);
            end
            if (k > 0) begin
                vectors++;
                if (f_pre - 1 != 1) begin
                    miscompares++;
                    $display("FAIL b2b_ipg%0d: got %0d idle cycles want 1", k, f_pre - 1);
                end
            end
        end
        repeat (4) tick();
        vectors++;
        if (pkts_sent !== 16'd3 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_done: pkts=%0d done=%b want 3/1", pkts_sent, done);
        end
        stop_run();
        exp_seq = 3;
    endtask

    task automatic test_full_stall();
        int n;
        int bad;
        logic [63:0] held;
        start_run(64, 1, 1'b0);
        fw.delete();
        n = 0;
        while (!(tx.pkt_tx_val && tx.pkt_tx_sop) && n < 200) begin
            tick();
            n++;
        end
        fw.push_back(tx.pkt_tx_data);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx.pkt_tx_val)
                fw.push_back(tx.pkt_tx_data);
        end
        held = tx.pkt_tx_data;
        tx.pkt_tx_full = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tx.pkt_tx_val !== 1'b0 || tx.pkt_tx_data !== held)
                bad++;
        end
        tx.pkt_tx_full = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_hold: %0d of 5 stall cycles wrong, want 0", bad);
        end
        n = 0;
        do begin
            tick();
            n++;
            if (tx.pkt_tx_val)
                fw.push_back(tx.pkt_tx_data);
        end while (!(tx.pkt_tx_val && tx.pkt_tx_eop) && n < 50);
        vectors++;
        if (fw.size() != 8) begin
            miscompares++;
            $display("FAIL full_words: got %0d words want 8", fw.size());
        end
        bad = 0;
        for (int i = 0; i < fw.size(); i++)
            if (fw[i] !== exp_word(exp_seq, 64, i))
                bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_data: %0d wrong words, want 0", bad);
        end
        stop_run();
        exp_seq++;
    endtask

    task automatic test_clamp();
        int bad;
        start_run(10, 1, 1'b0);
        collect_frame();
        vectors++;
        if (fw.size() != 8 || fw[0][15:0] !== 16'd64) begin
            miscompares++;
            $display("FAIL clamp_low: words=%0d len=%0d want 8/64", fw.size(), fw.size() > 0 ? fw[0][15:0] : 16'hFFFF);
        end
        stop_run();
        exp_seq++;
        start_run(2000, 1, 1'b0);
        collect_frame();
        vectors++;
        if (fw.size() != 190 || f_mod !== 3'd6 || fw[0][15:0] !== 16'd1518) begin
            miscompares++;
            $display("FAIL clamp_high: words=%0d mod=%0d len=%0d want 190/6/1518", fw.size(), f_mod,
                     fw.size() > 0 ? fw[0][15:0] : 16'hFFFF);
        end
        bad = 0;
        for (int i = 0; i < fw.size(); i++)
            if (fw[i] !== exp_word(exp_seq, 1518, i))
                bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clamp_high_data: %0d wrong words, want 0", bad);
        end
        stop_run();
        exp_seq++;
    endtask

    task automatic test_rand_len();
        logic [15:0] lfsr;
        int          len;
        do_reset();
        exp_seq = 0;
        lfsr = 16'hACE1;
        start_run(64, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            len = clampb(int'(lfsr[10:0]));
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            collect_frame();
            vectors++;
            if (f_ok != 1 || fw.size() != (len + 7) / 8 || fw[0][15:0] !== 16'(len) || f_mod !== 3'(len)) begin
                miscompares++;
                $display("FAIL rand_frame%0d: words=%0d len=%0d mod=%0d want %0d/%0d/%0d", k, fw.size(),
                         fw.size() > 0 ? fw[0][15:0] : 16'hFFFF, f_mod, (len + 7) / 8, len, len % 8);
            end else begin
                vectors++;
                if (fw[fw.size()-1] !== exp_word(exp_seq, len, fw.size() - 1)) begin
                    miscompares++;
                    $display("FAIL rand_last%0d: got %h want %h", k, fw[fw.size()-1], exp_word(exp_seq, len, fw.size() - 1));
                end
            end
            exp_seq++;
        end
        stop_run();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        start_run(64, 1, 1'b0);
        n = 0;
        while (!(tx.pkt_tx_val && tx.pkt_tx_sop) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({tx.pkt_tx_val, tx.pkt_tx_sop, tx.pkt_tx_eop, tx.pkt_tx_mod} !== 6'd0 || tx.pkt_tx_data !== 64'd0
            || {busy, done, pkts_sent} !== 18'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: val=%b data=%h busy=%b pkts=%0d want all 0", tx.pkt_tx_val,
                     tx.pkt_tx_data, busy, pkts_sent);
        end
        rst = 1'b0;
        collect_frame();
        vectors++;
        if (f_ok != 1 || fw[0] !== 64'h00000000_A5C3_0040) begin
            miscompares++;
            $display("FAIL midreset_restart: ok=%0d w0=%h want 1/00000000a5c30040", f_ok, fw.size() > 0 ? fw[0] : 64'd0);
        end
        stop_run();
    endtask

    initial begin
        tx.pkt_tx_full = 1'b0;
        test_reset();
        test_fixed_64();
        test_fixed_65();
        test_back_to_back();
        test_full_stall();
        test_clamp();
        test_rand_len();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1);
    end

endmodule
